// File: rtl/uart_rx_cfg_if.sv
// Line-side input and frame-side outputs of the configurable UART receiver.
interface uart_rx_cfg_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 i_Rx_Serial;
    logic                 o_Rx_DV;
    logic [DATA_BITS-1:0] o_Rx_Byte;
    logic                 o_Parity_Err;
    logic                 o_Frame_Err;
    logic                 o_Break;
    logic                 o_Busy;

    modport master (
        output i_Rx_Serial,
        input  o_Rx_DV, o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Break, o_Busy
    );

    modport slave (
        input  i_Rx_Serial,
        output o_Rx_DV, o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Break, o_Busy
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, none/odd/even parity, 1 or 2 stop bits.
// Define UART_RX_MAJORITY_EN to take every sample as a 2-of-3 vote around the bit centre.
module uart_rx_cfg #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic         i_Clock,
    input  logic         i_Rst_n,
    uart_rx_cfg_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] START_CENTRE = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] BIT_CENTRE   = CNT_W'(CLKS_PER_BIT - 1);

    if ((CLKS_PER_BIT < 8) || (CLKS_PER_BIT > 65535)) begin : g_bad_clks
        $error("uart_rx_cfg: CLKS_PER_BIT must be 8..65535");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data
        $error("uart_rx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE > 2) begin : g_bad_parity
        $error("uart_rx_cfg: PARITY_MODE must be 0, 1 or 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
        $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_sync;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_acc;
    logic                 par_err;
    logic                 stop_idx;
    logic                 ferr_acc;
    logic                 zero_acc;

    logic sampling_c;
    logic at_centre_c;
    logic sample_c;
    logic bit_c;

    always_comb begin
        sampling_c  = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
        at_centre_c = sampling_c && (cnt == ((state == START) ? START_CENTRE : BIT_CENTRE));
    end

`ifdef UART_RX_MAJORITY_EN
    // The vote is resolved one cycle after the centre, once centre+1 has arrived.
    logic hist_1;
    logic hist_2;
    logic pending;

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            hist_1  <= 1'b1;
            hist_2  <= 1'b1;
            pending <= 1'b0;
        end else begin
            hist_1  <= rx_sync;
            hist_2  <= hist_1;
            pending <= at_centre_c;
        end
    end

    always_comb begin
        sample_c = pending;
        bit_c    = (hist_2 & hist_1) | (hist_2 & rx_sync) | (hist_1 & rx_sync);
    end
`else
    always_comb begin
        sample_c = at_centre_c;
        bit_c    = rx_sync;
    end
`endif

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            state            <= IDLE;
            rx_meta          <= 1'b1;
            rx_sync          <= 1'b1;
            cnt              <= '0;
            bit_idx          <= '0;
            shift            <= '0;
            par_acc          <= 1'b0;
            par_err          <= 1'b0;
            stop_idx         <= 1'b0;
            ferr_acc         <= 1'b0;
            zero_acc         <= 1'b0;
            bus.o_Rx_DV      <= 1'b0;
            bus.o_Rx_Byte    <= '0;
            bus.o_Parity_Err <= 1'b0;
            bus.o_Frame_Err  <= 1'b0;
            bus.o_Break      <= 1'b0;
            bus.o_Busy       <= 1'b0;
        end else begin
            rx_meta     <= bus.i_Rx_Serial;
            rx_sync     <= rx_meta;
            bus.o_Rx_DV <= 1'b0;
            // Counter restarts at each centre so later centres are one bit period apart.
            if (!sampling_c || at_centre_c) cnt <= '0;
            else                            cnt <= cnt + CNT_W'(1);

            case (state)
                IDLE: begin
                    if (!rx_sync) begin
                        state      <= START;
                        bus.o_Busy <= 1'b1;
                    end
                end
                START: begin
                    if (sample_c) begin
                        if (bit_c) begin
                            state      <= IDLE;
                            cnt        <= '0;
                            bus.o_Busy <= 1'b0;
                        end else begin
                            state    <= DATA;
                            bit_idx  <= '0;
                            par_acc  <= 1'b0;
                            par_err  <= 1'b0;
                            stop_idx <= 1'b0;
                            ferr_acc <= 1'b0;
                            zero_acc <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (sample_c) begin
                        shift    <= {bit_c, shift[DATA_BITS-1:1]};
                        par_acc  <= par_acc ^ bit_c;
                        zero_acc <= zero_acc & ~bit_c;
                        if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                            bit_idx <= '0;
                            state   <= (PARITY_MODE != 0) ? PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (sample_c) begin
                        par_err  <= (PARITY_MODE == 1) ? ~(par_acc ^ bit_c) : (par_acc ^ bit_c);
                        zero_acc <= zero_acc & ~bit_c;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (sample_c) begin
                        if ((STOP_BITS == 1) || stop_idx) begin
                            bus.o_Rx_DV      <= 1'b1;
                            bus.o_Rx_Byte    <= shift;
                            bus.o_Parity_Err <= par_err;
                            bus.o_Frame_Err  <= ferr_acc | ~bit_c;
                            bus.o_Break      <= zero_acc & ~bit_c;
                            cnt              <= '0;
                            if (ferr_acc | ~bit_c) begin
                                state <= WAIT_HIGH;
                            end else begin
                                state      <= IDLE;
                                bus.o_Busy <= 1'b0;
                            end
                        end else begin
                            stop_idx <= 1'b1;
                            ferr_acc <= ~bit_c;
                            zero_acc <= zero_acc & ~bit_c;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rx_sync) begin
                        state      <= IDLE;
                        bus.o_Busy <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    bus.o_Busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
